// File: rtl/divisor_secuencial_pkg.sv
// Shared state encoding and default operand width for the sequential divider.
package divisor_pkg;

  localparam int DIV_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/divisor_secuencial_if.sv
// Request/result bundle of the sequential divider: operands and start in, status and results out.
interface divisor_secuencial_if
  import divisor_pkg::*;
#(
  parameter int N = DIV_W_DEFAULT
);

  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         div_zero;

  modport master (
    output start, A, B,
    input  busy, done, Q, R, div_zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, Q, R, div_zero
  );

endinterface

// File: rtl/divisor_secuencial_paso.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module divisor_paso #(
  parameter int N = 8
) (
  input  logic [N-1:0] rem,
  input  logic         bit_in,
  input  logic [N-1:0] b,
  output logic [N-1:0] rem_nxt,
  output logic         q_bit
);

  logic [N:0] shifted;

  assign shifted = {rem, bit_in};
  assign q_bit   = (shifted >= {1'b0, b});

  // The true difference is always below b, so the low N bits of the
  // modular subtraction are exact; only the compare needs the extra bit.
  assign rem_nxt = q_bit ? (shifted[N-1:0] - b) : shifted[N-1:0];

endmodule

// File: rtl/divisor_secuencial.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor skips the iteration and raises div_zero.
module divisor_secuencial
  import divisor_pkg::*;
#(
  parameter int N = DIV_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  divisor_secuencial_if.slave  bus
);

  localparam int CW = $clog2(N) + 1;

  div_state_e   state;
  logic [CW-1:0] cnt;
  logic [N-1:0] dvd;
  logic [N-1:0] dvs;
  logic [N-1:0] rem;
  logic [N-1:0] q_sr;
  logic [N-1:0] q_out;
  logic [N-1:0] r_out;
  logic         done_r;
  logic [N-1:0] rem_nxt;
  logic         q_bit;
  logic         b_zero;

  divisor_paso #(.N(N)) u_paso (
    .rem     (rem),
    .bit_in  (dvd[N-1]),
    .b       (dvs),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

`ifdef DIV_ZERO_DETECT_EN
  assign b_zero = (bus.B == '0);
`else
  assign b_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      q_sr   <= '0;
      q_out  <= '0;
      r_out  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd <= bus.A;
            dvs <= bus.B;
            cnt <= CW'(N - 1);
            if (b_zero) begin
              // Preload the natural divide-by-zero answer and skip iterating.
              q_sr  <= '1;
              rem   <= bus.A;
              state <= DONE;
            end else begin
              q_sr  <= '0;
              rem   <= '0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem  <= rem_nxt;
          q_sr <= {q_sr[N-2:0], q_bit};
          dvd  <= {dvd[N-2:0], 1'b0};
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          q_out  <= q_sr;
          r_out  <= rem;
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dz_pend;
  logic dz_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dz_pend <= 1'b0;
      dz_out  <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        dz_pend <= b_zero;
      end
      if (state == DONE) begin
        dz_out <= dz_pend;
      end
    end
  end

  assign bus.div_zero = dz_out;
`else
  assign bus.div_zero = 1'b0;
`endif

  assign bus.busy = (state == RUN);
  assign bus.done = done_r;
  assign bus.Q    = q_out;
  assign bus.R    = r_out;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed self-checking bench for divisor_secuencial with N=8.
module tb_divisor_secuencial;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  divisor_secuencial_if #(.N(8)) bus ();

  divisor_secuencial #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", tag, obs, exp);
    end
  endtask

  // Caller must be positioned away from the rising edge (at a falling edge).
  task automatic do_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input int exp_busy,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz);
    int lat;
    int nbusy;
    lat   = 0;
    nbusy = 0;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      if (bus.busy) nbusy++;
      @(posedge clk); #1;
      if (bus.done) lat = i;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, nbusy, exp_busy);
    chk({tag, "_Q"}, bus.Q, eq);
    chk({tag, "_R"}, bus.R, er);
    chk({tag, "_div_zero"}, bus.div_zero, edz);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, bus.done, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int nd;
    int t [3];
    logic [7:0] qq [3];
    logic [7:0] rr [3];

    n_chk = 0;
    n_err = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #1;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_Q", bus.Q, 8'd0);
    chk("reset_R", bus.R, 8'd0);
    chk("reset_div_zero", bus.div_zero, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Start issued for the very first edge after reset release.
    do_div("d200_7", 8'd200, 8'd7, 9, 8, 8'd28, 8'd4, 1'b0);
    do_div("d5_9", 8'd5, 8'd9, 9, 8, 8'd0, 8'd5, 1'b0);
`ifdef DIV_ZERO_DETECT_EN
    do_div("d100_0", 8'd100, 8'd0, 1, 0, 8'd255, 8'd100, 1'b1);
`else
    do_div("d100_0", 8'd100, 8'd0, 9, 8, 8'd255, 8'd100, 1'b0);
`endif
    do_div("d255_1", 8'd255, 8'd1, 9, 8, 8'd255, 8'd0, 1'b0);

    // Start re-pulsed with new operands while iterating.
    bus.A = 8'd200; bus.B = 8'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.A = 8'd9; bus.B = 8'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        nd++;
        qq[0] = bus.Q;
        rr[0] = bus.R;
      end
    end
    chk("ignore_start_done_count", nd, 1);
    chk("ignore_start_Q", qq[0], 8'd28);
    chk("ignore_start_R", rr[0], 8'd4);

    // Reset four cycles into an iteration.
    @(negedge clk);
    bus.A = 8'd200; bus.B = 8'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy", bus.busy, 1'b0);
    chk("midrun_rst_done", bus.done, 1'b0);
    chk("midrun_rst_Q", bus.Q, 8'd0);
    chk("midrun_rst_R", bus.R, 8'd0);
    chk("midrun_rst_div_zero", bus.div_zero, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) nd++;
    end
    chk("aborted_no_activity", nd, 0);
    @(negedge clk);
    do_div("d81_9", 8'd81, 8'd9, 9, 8, 8'd9, 8'd0, 1'b0);

    // Start held high across three back-to-back divisions.
    bus.A = 8'd200; bus.B = 8'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    nd = 0;
    for (int i = 1; i <= 35; i++) begin
      if (i == 1)  begin bus.A = 8'd100; bus.B = 8'd9; end
      if (i == 11) begin bus.A = 8'd81;  bus.B = 8'd9; end
      if (i == 21) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) begin
        if (nd < 3) begin
          t[nd]  = i;
          qq[nd] = bus.Q;
          rr[nd] = bus.R;
        end
        nd++;
      end
    end
    chk("b2b_done_count", nd, 3);
    if (nd >= 3) begin
      chk("b2b_first_latency", t[0], 9);
      chk("b2b_gap_1", t[1] - t[0], 10);
      chk("b2b_gap_2", t[2] - t[1], 10);
      chk("b2b_Q0", qq[0], 8'd28);
      chk("b2b_R0", rr[0], 8'd4);
      chk("b2b_Q1", qq[1], 8'd11);
      chk("b2b_R1", rr[1], 8'd1);
      chk("b2b_Q2", qq[2], 8'd9);
      chk("b2b_R2", rr[2], 8'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/divisor_secuencial.md
DIVISOR_SECUENCIAL -- requirements
Module: divisor_secuencial

Interface
REQ-001 SHALL have parameter N, default 8, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a division, sampled on clk.
REQ-005 SHALL have port A  input  N  dividend (operand 1 from keypad entry).
REQ-006 SHALL have port B  input  N  divisor (operand 2 from keypad entry).
REQ-007 SHALL have port busy  output  1  high while iterating.
REQ-008 SHALL have port done  output  1  one-cycle pulse, Q/R valid.
REQ-009 SHALL have port Q  output  N  registered quotient, feeds display_value path.
REQ-010 SHALL have port R  output  N  registered remainder.
REQ-011 SHALL have port div_zero  output  1  divide-by-zero flag (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE with start=1, latch A and B into internal registers, clear partial remainder and quotient shift register, load iteration counter with N-1, go to RUN.
REQ-014 SHALL, in RUN, perform one restoring step per cycle: shift {rem, dividend MSB} left, subtract B if rem >= B, shift quotient bit in (1 if subtracted, else 0), decrement counter.
REQ-015 SHALL compare/subtract at N+1 bits so no overflow occurs for B up to 2^N-1.
REQ-016 SHALL leave RUN after exactly N cycles, counter reaching 0, then enter DONE.
REQ-017 SHALL, in DONE, update Q and R, assert done for exactly one cycle, return to IDLE next cycle.
REQ-018 SHALL provide latency: start sampled at edge k -> done high during the cycle after edge k+N+1 (N+1 cycles).
REQ-019 SHALL hold Q, R, div_zero stable from DONE until the next DONE.
REQ-020 SHALL assert busy in RUN only; busy=0 in IDLE and DONE.
REQ-021 SHALL ignore start in RUN and DONE; no queuing; A/B changes after latch have no effect.
REQ-022 SHALL, with start held high continuously, start a new division on every IDLE visit (back-to-back, period N+2).
REQ-023 SHALL produce Q=0, R=A when A<B; Q=A, R=0 when B=1.

Reset
REQ-024 SHALL, on rst=1 at any time including mid-RUN, asynchronously force IDLE, busy=0, done=0, Q=0, R=0, div_zero=0, counter=0; the aborted division SHALL produce no done.
REQ-025 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-026 SHALL honour macro DIV_ZERO_DETECT_EN.
REQ-027 SHALL, with DIV_ZERO_DETECT_EN defined, when B=0 at start, skip RUN: IDLE -> DONE directly, Q=all ones, R=A, div_zero=1, done one cycle after start sample.
REQ-028 SHALL, without DIV_ZERO_DETECT_EN, run B=0 through the normal N-cycle algorithm (natural result Q=all ones, R=A) and tie div_zero to 0.
REQ-029 SHALL clear div_zero on every non-zero-divisor completion.

Structure
REQ-030 SHALL place the state enum (IDLE/RUN/DONE) and default width constant in package divisor_pkg.
REQ-031 SHALL place one restoring step (inputs rem, next bit, B; outputs new rem, quotient bit) in combinational sub-module divisor_paso, instanced once.
REQ-032 SHALL keep the counter width $clog2(N)+1.

Verification
REQ-033 SHALL test N=8, A=200, B=7, start pulse -> busy 8 cycles, done 9 cycles after start, Q=28, R=4.
REQ-034 SHALL test A=5, B=9 -> Q=0, R=5; and A=255, B=1 -> Q=255, R=0.
REQ-035 SHALL test A=100, B=0 with macro -> done 1 cycle after start, Q=255, R=100, div_zero=1; without macro -> done at 9 cycles, same Q/R, div_zero=0.
REQ-036 SHALL test start re-pulsed and A/B changed during RUN (A=200, B=7 then A=9, B=3) -> single done, Q=28, R=4.
REQ-037 SHALL test rst asserted 4 cycles into RUN -> immediate IDLE, outputs 0, no done; next start A=81, B=9 -> Q=9, R=0.
REQ-038 SHALL test start held high for 3 divisions -> done pulses exactly 10 cycles apart, results match each latched operand pair.
